// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit. The pipeline side uses the master modport,
// the unit uses the slave modport.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_addr_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;
  logic            busy_o;

  modport master (
    output flush_i, valid_i, op_i, rs1_i, rs2_i, rd_addr_i, ready_i,
    input  ready_o, valid_o, result_o, rd_addr_o, busy_o
  );

  modport slave (
    input  flush_i, valid_i, op_i, rs1_i, rs2_i, rd_addr_i, ready_i,
    output ready_o, valid_o, result_o, rd_addr_o, busy_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M multiply/divide unit. Multiplies use shift-add and
// divides use restoring division, one bit per cycle over XLEN cycles.
// Divide-by-zero and signed overflow resolve at accept and skip the iterations.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// combinational multiplier captured at the accept edge instead.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  muldiv_unit_if.slave  mdBus
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t r_state;
  state_t w_nextState;

  logic             w_ready;
  logic             w_valid;
  logic             w_busy;

  logic [2:0]       r_op;
  logic [4:0]       r_rdAddr;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_result;
  logic [2*XLEN-1:0] r_prod;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic             r_bSigned;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_divisor;
  logic             r_negQuo;
  logic             r_negRem;

  logic             w_accept;
  logic             w_isDivOp;
  logic             w_divSigned;
  logic             w_divZero;
  logic             w_overflow;
  logic             w_special;
  logic             w_shortcut;
  logic             w_aSigned;
  logic             w_bSigned;
  logic             w_aNeg;
  logic             w_bNeg;
  logic [XLEN-1:0]  w_absA;
  logic [XLEN-1:0]  w_absB;
  logic [2*XLEN-1:0] w_mcandExt;
  logic [2*XLEN-1:0] w_prodNext;
  logic [XLEN:0]    w_remShift;
  logic             w_remGe;
  logic [XLEN-1:0]  w_remDiff;
  logic [XLEN-1:0]  w_remNext;
  logic [XLEN-1:0]  w_quoNext;
  logic [XLEN-1:0]  w_mulResult;
  logic [XLEN-1:0]  w_divResult;
  logic [XLEN-1:0]  w_finalResult;
  logic [XLEN-1:0]  w_specialResult;

  // MUL keeps the low half of the product, MULH/MULHSU/MULHU the high half.
  function automatic logic [XLEN-1:0] mulSelect(input logic [1:0] op,
                                                input logic [2*XLEN-1:0] prod);
    return (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // Request decode: signedness, magnitudes and the shortcut cases.
  assign w_accept    = mdBus.valid_i && (r_state == IDLE) && !mdBus.flush_i;
  assign w_isDivOp   = mdBus.op_i[2];
  assign w_divSigned = mdBus.op_i[2] & ~mdBus.op_i[0];
  assign w_aSigned   = ~mdBus.op_i[2] & (mdBus.op_i[1] ^ mdBus.op_i[0]);
  assign w_bSigned   = ~mdBus.op_i[2] & (mdBus.op_i[1:0] == 2'b01);
  assign w_divZero   = (mdBus.rs2_i == '0);
  assign w_overflow  = w_divSigned && (mdBus.rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (mdBus.rs2_i == '1);
  assign w_special   = w_isDivOp && (w_divZero || w_overflow);
  assign w_aNeg      = w_divSigned & mdBus.rs1_i[XLEN-1];
  assign w_bNeg      = w_divSigned & mdBus.rs2_i[XLEN-1];
  assign w_absA      = w_aNeg ? -mdBus.rs1_i : mdBus.rs1_i;
  assign w_absB      = w_bNeg ? -mdBus.rs2_i : mdBus.rs2_i;
  assign w_mcandExt  = {{XLEN{w_aSigned & mdBus.rs1_i[XLEN-1]}}, mdBus.rs1_i};

  assign w_specialResult = w_divZero ? (mdBus.op_i[1] ? mdBus.rs1_i : '1)
                                     : (mdBus.op_i[1] ? '0 : mdBus.rs1_i);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_mplierExt;
  logic [2*XLEN-1:0] w_fastProd;
  assign w_mplierExt = {{XLEN{w_bSigned & mdBus.rs2_i[XLEN-1]}}, mdBus.rs2_i};
  assign w_fastProd  = w_mcandExt * w_mplierExt;
  assign w_shortcut  = w_special || !w_isDivOp;
`else
  assign w_shortcut  = w_special;
`endif

  // One shift-add step; a signed multiplier's top bit carries negative weight,
  // so the last step subtracts the shifted multiplicand.
  assign w_prodNext = r_mplier[0]
                      ? ((r_bSigned && (r_count == LAST_ITER)) ? (r_prod - r_mcand)
                                                               : (r_prod + r_mcand))
                      : r_prod;

  // One restoring-division step on magnitudes.
  assign w_remShift = {r_rem, r_quo[XLEN-1]};
  assign w_remGe    = (w_remShift >= {1'b0, r_divisor});
  assign w_remDiff  = w_remShift[XLEN-1:0] - r_divisor;
  assign w_remNext  = w_remGe ? w_remDiff : w_remShift[XLEN-1:0];
  assign w_quoNext  = {r_quo[XLEN-2:0], w_remGe};

  assign w_mulResult   = mulSelect(r_op[1:0], w_prodNext);
  assign w_divResult   = r_op[1] ? (r_negRem ? -w_remNext : w_remNext)
                                 : (r_negQuo ? -w_quoNext : w_quoNext);
  assign w_finalResult = r_op[2] ? w_divResult : w_mulResult;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic; flush aborts from any state.
  always_comb begin
    w_nextState = r_state;
    if (mdBus.flush_i) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_accept) w_nextState = w_shortcut ? DONE : CALC;
        CALC: if (r_count == LAST_ITER) w_nextState = DONE;
        DONE: if (mdBus.ready_i) w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Handshake and stall outputs decoded from the state.
  always_comb begin
    w_ready = (r_state == IDLE);
    w_valid = (r_state == DONE);
    w_busy  = (r_state == CALC) || (r_state == DONE);
  end

  // Datapath: capture at accept, then one iteration per CALC cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op      <= '0;
      r_rdAddr  <= '0;
      r_count   <= '0;
      r_result  <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_bSigned <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_negQuo  <= 1'b0;
      r_negRem  <= 1'b0;
    end else if (w_accept) begin
      r_op      <= mdBus.op_i;
      r_rdAddr  <= mdBus.rd_addr_i;
      r_count   <= '0;
      r_prod    <= '0;
      r_mcand   <= w_mcandExt;
      r_mplier  <= mdBus.rs2_i;
      r_bSigned <= w_bSigned;
      r_rem     <= '0;
      r_quo     <= w_absA;
      r_divisor <= w_absB;
      r_negQuo  <= w_aNeg ^ w_bNeg;
      r_negRem  <= w_aNeg;
      if (w_special) begin
        r_result <= w_specialResult;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (!w_isDivOp) begin
        r_result <= mulSelect(mdBus.op_i[1:0], w_fastProd);
      end
`endif
    end else if ((r_state == CALC) && !mdBus.flush_i) begin
      r_prod   <= w_prodNext;
      r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
      r_rem    <= w_remNext;
      r_quo    <= w_quoNext;
      if (r_count == LAST_ITER) r_result <= w_finalResult;
      else                      r_count  <= r_count + CNT_W'(1);
    end
  end

  assign mdBus.ready_o   = w_ready;
  assign mdBus.valid_o   = w_valid;
  assign mdBus.busy_o    = w_busy;
  assign mdBus.result_o  = r_result;
  assign mdBus.rd_addr_o = r_rdAddr;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with a transaction-level
// reference model and a per-cycle output comparison.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic checkEn;
  int   assertCount = 0;
  int   failCount = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  muldiv_unit_if #(.XLEN(XLEN)) mdBus();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mdBus (mdBus.slave)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_BUSY, M_DONE} mPhase_t;
  mPhase_t     mPhase = M_IDLE;
  int          mRemain = 0;
  logic [31:0] mResult = '0;
  logic [4:0]  mTag = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural RV32M result computed with plain wide arithmetic.
  function automatic logic [31:0] refCompute(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0]        prod;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sbu;
    logic               ovf;
    logic [31:0]        res;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sbu = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    res = '0;
    case (op)
      3'd0: begin prod = {32'b0, a} * {32'b0, b}; res = prod[31:0]; end
      3'd1: begin prod = sa * sb;                 res = prod[63:32]; end
      3'd2: begin prod = sa * sbu;                res = prod[63:32]; end
      3'd3: begin prod = {32'b0, a} * {32'b0, b}; res = prod[63:32]; end
      3'd4: res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: res = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: res = (b == 0) ? a : a % b;
    endcase
    return res;
  endfunction

  // Ops that complete without iterating.
  function automatic bit isShortcut(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    bit sgn;
    sgn = op[2] && !op[0];
    if (!op[2]) return FAST_MUL;
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Transaction model: idle -> busy for XLEN edges (or straight to done) -> idle.
  always @(posedge clk) begin
    if (rst) begin
      mPhase = M_IDLE; mResult = '0; mTag = '0; mRemain = 0;
    end else if (mdBus.flush_i) begin
      mPhase = M_IDLE;
    end else begin
      case (mPhase)
        M_IDLE: if (mdBus.valid_i) begin
          mResult = refCompute(mdBus.op_i, mdBus.rs1_i, mdBus.rs2_i);
          mTag    = mdBus.rd_addr_i;
          if (isShortcut(mdBus.op_i, mdBus.rs1_i, mdBus.rs2_i)) mPhase = M_DONE;
          else begin mPhase = M_BUSY; mRemain = XLEN; end
        end
        M_BUSY: begin
          mRemain--;
          if (mRemain == 0) mPhase = M_DONE;
        end
        default: if (mdBus.ready_i) mPhase = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc ready_o", 32'(mdBus.ready_o), 32'(mPhase == M_IDLE));
      checkOutput("cyc valid_o", 32'(mdBus.valid_o), 32'(mPhase == M_DONE));
      checkOutput("cyc busy_o",  32'(mdBus.busy_o),  32'(mPhase != M_IDLE));
      if (mPhase == M_DONE) begin
        checkOutput("cyc result_o",  mdBus.result_o, mResult);
        checkOutput("cyc rd_addr_o", 32'(mdBus.rd_addr_o), 32'(mTag));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    mdBus.valid_i = 1'b1; mdBus.op_i = op; mdBus.rs1_i = a; mdBus.rs2_i = b;
    mdBus.rd_addr_i = tag;
    @(posedge clk); #1;
    mdBus.valid_i = 1'b0;
    mdBus.op_i = 3'($urandom); mdBus.rs1_i = $urandom; mdBus.rs2_i = $urandom;
    mdBus.rd_addr_i = 5'($urandom);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag,
                               input logic [31:0] expRes, input int holdCycles);
    int edges;
    int expEdges;
    expEdges = isShortcut(op, a, b) ? 0 : XLEN;
    issue(op, a, b, tag);
    checkOutput("model result", mResult, expRes);
    edges = 0;
    while (mdBus.valid_o !== 1'b1 && edges < 3 * XLEN) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("latency edges", 32'(edges), 32'(expEdges));
    checkOutput("result_o", mdBus.result_o, expRes);
    checkOutput("rd_addr_o", 32'(mdBus.rd_addr_o), 32'(tag));
    repeat (holdCycles) begin
      @(posedge clk); #1;
      checkOutput("hold valid_o", 32'(mdBus.valid_o), 32'd1);
      checkOutput("hold ready_o", 32'(mdBus.ready_o), 32'd0);
      checkOutput("hold result_o", mdBus.result_o, expRes);
      checkOutput("hold rd_addr_o", 32'(mdBus.rd_addr_o), 32'(tag));
    end
    mdBus.ready_i = 1'b1;
    @(posedge clk); #1;
    mdBus.ready_i = 1'b0;
    checkOutput("post-handshake ready_o", 32'(mdBus.ready_o), 32'd1);
    checkOutput("post-handshake valid_o", 32'(mdBus.valid_o), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tagName);
    checkOutput({tagName, " ready_o"},   32'(mdBus.ready_o), 32'd1);
    checkOutput({tagName, " valid_o"},   32'(mdBus.valid_o), 32'd0);
    checkOutput({tagName, " busy_o"},    32'(mdBus.busy_o), 32'd0);
    checkOutput({tagName, " result_o"},  mdBus.result_o, 32'd0);
    checkOutput({tagName, " rd_addr_o"}, 32'(mdBus.rd_addr_o), 32'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    int seen;
    rst = 1'b1; checkEn = 1'b0;
    mdBus.flush_i = 1'b0; mdBus.valid_i = 1'b0; mdBus.op_i = '0;
    mdBus.rs1_i = '0; mdBus.rs2_i = '0; mdBus.rd_addr_i = '0; mdBus.ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkEn = 1'b1;
    checkResetOutputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 0);
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 0);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 0);
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 0);
    applyStimulus(3'd1, 32'hFFFF_FFFD, 32'd7,         5'd5,  32'hFFFF_FFFF, 0);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 0);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 0);
    applyStimulus(3'd5, 32'd100,       32'd7,         5'd8,  32'd14,        0);
    applyStimulus(3'd7, 32'd100,       32'd7,         5'd9,  32'd2,         0);
    applyStimulus(3'd4, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 0);
    applyStimulus(3'd6, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,         0);
    applyStimulus(3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd6, 32'd5,         32'd0,         5'd14, 32'd5,         0);
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         0);
    applyStimulus(3'd5, 32'd100,       32'd7,         5'h0A, 32'd14,        5);

    // Flush during iteration 10 of a DIVU.
    issue(3'd5, 32'hFFFF_1234, 32'd3, 5'd17);
    repeat (10) begin @(posedge clk); #1; end
    mdBus.flush_i = 1'b1;
    @(posedge clk); #1;
    mdBus.flush_i = 1'b0;
    checkOutput("flush ready_o", 32'(mdBus.ready_o), 32'd1);
    checkOutput("flush valid_o", 32'(mdBus.valid_o), 32'd0);
    seen = 0;
    repeat (2 * XLEN) begin
      @(posedge clk); #1;
      if (mdBus.valid_o === 1'b1) seen++;
    end
    checkOutput("flush no result", 32'(seen), 32'd0);
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd18, 32'd12, 0);

    // Flush while a result waits in DONE.
    issue(3'd5, 32'd9, 32'd0, 5'd19);
    mdBus.flush_i = 1'b1;
    @(posedge clk); #1;
    mdBus.flush_i = 1'b0;
    checkOutput("done-flush ready_o", 32'(mdBus.ready_o), 32'd1);
    checkOutput("done-flush valid_o", 32'(mdBus.valid_o), 32'd0);

    // Reset in the middle of a divide clears every output.
    issue(3'd4, 32'd1000, 32'hFFFF_FFFD, 5'd20);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs("mid-op reset");
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(3'd7, 32'd100, 32'd7, 5'd21, 32'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
